// File: rtl/seq_detect_fsm.sv
// Parametrised serial pattern detector: KMP-style prefix-state FSM with
// elaboration-time overlap and Mealy/Moore selection plus a saturating match counter.
module seq_detect_fsm #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
    parameter bit                 OVERLAP = 1'b1,
    parameter bit                 MOORE   = 1'b0,
    parameter int                 CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clear,
    input  logic             x_in,
    output logic             y_out,
    output logic [CNT_W-1:0] match_count,
    output logic [4:0]       state_out
);

    localparam int MAX_K = MOORE ? PAT_LEN : PAT_LEN - 1;

    typedef logic [31:0][4:0] tbl_t;

    // Bit i of the pattern in arrival order (i = 0 is received first).
    function automatic logic pat_bit(input int i);
        logic [PAT_LEN-1:0] t;
        t = PATTERN >> (PAT_LEN - 1 - i);
        return t[0];
    endfunction

    // Longest pattern prefix that is a suffix of (first k pattern bits, then b).
    function automatic int longest_match(input int k, input logic b);
        int   best;
        int   top;
        int   pos;
        logic ok;
        logic s;
        best = 0;
        top  = (k + 1 < PAT_LEN) ? k + 1 : PAT_LEN;
        for (int l = 1; l <= top; l++) begin
            ok = 1'b1;
            for (int i = 0; i < l; i++) begin
                pos = k + 1 - l + i;
                s   = (pos == k) ? b : pat_bit(pos);
                if (s != pat_bit(i)) ok = 1'b0;
            end
            if (ok) best = l;
        end
        return best;
    endfunction

    function automatic int border_len();
        int   best;
        logic ok;
        best = 0;
        for (int l = 1; l < PAT_LEN; l++) begin
            ok = 1'b1;
            for (int i = 0; i < l; i++) begin
                if (pat_bit(PAT_LEN - l + i) != pat_bit(i)) ok = 1'b0;
            end
            if (ok) best = l;
        end
        return best;
    endfunction

    // Full transition table for one input bit value; unused entries stay 0.
    function automatic tbl_t build_tbl(input logic b);
        tbl_t t;
        int   src;
        int   n;
        int   bord;
        t    = '0;
        bord = border_len();
        for (int k = 0; k <= MAX_K; k++) begin
            // The Moore "match" state behaves like the state the search resumes from.
            src = (k == PAT_LEN) ? (OVERLAP ? bord : 0) : k;
            n   = longest_match(src, b);
            if (n == PAT_LEN && !MOORE) n = OVERLAP ? bord : 0;
            t[5'(k)] = 5'(n);
        end
        return t;
    endfunction

    localparam tbl_t NXT0 = build_tbl(1'b0);
    localparam tbl_t NXT1 = build_tbl(1'b1);

    logic [4:0] k_q;
    logic [4:0] k_d;
    logic [4:0] k_step;
    logic       legal;
    logic       done;

    assign legal  = (k_q <= 5'(MAX_K));
    assign k_step = x_in ? NXT1[k_q] : NXT0[k_q];

    always_comb begin
        if (MOORE) done = en & legal & (k_step == 5'(PAT_LEN));
        else       done = en & (k_q == 5'(PAT_LEN - 1)) & (x_in == PATTERN[0]);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) k_q <= '0;
        else        k_q <= k_d;
    end

    // NOTE: k_d gets a default before any branch so no path leaves it
    // unassigned, which would infer a latch.
    always_comb begin
        k_d = k_q;
        if (clear || !legal) k_d = '0;
        else if (en)         k_d = k_step;
    end

    always_comb begin
        if (MOORE) y_out = (k_q == 5'(PAT_LEN));
        else       y_out = reset & done;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                              match_count <= '0;
        else if (clear)                          match_count <= '0;
        else if (done && (match_count != '1))    match_count <= match_count + 1'b1;
    end

    assign state_out = k_q;

endmodule

// File: tb/tb_seq_detect_fsm.sv
// Self-checking bench: four detector configurations driven from vector tables
// and hand-written sequences, expectations queued and popped after each edge.
module tb_seq_detect_fsm;

    typedef struct {
        logic       en;
        logic       clr;
        logic       x;
        logic       chk_y;
        logic       y;
        logic [7:0] cnt;
        logic [7:0] st;
    } vec_t;

    logic clk;
    logic reset;
    logic en_d;
    logic clr_d;
    logic x_d;
    int   sel;

    logic       y0, y1, y2, y3;
    logic [7:0] cnt0, cnt1, cnt2;
    logic [1:0] cnt3;
    logic [4:0] st0, st1, st2, st3;

    logic       y_s;
    logic [7:0] cnt_s;
    logic [4:0] st_s;

    int   total;
    int   bad;
    vec_t sb_q[$];

    vec_t tab_a [19];
    vec_t tab_b [7];
    vec_t tab_c [10];

    // 0: overlap Mealy, 1: non-overlap Mealy, 2: overlap Moore, 3: overlap Mealy with 2-bit counter
    seq_detect_fsm #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .MOORE(1'b0), .CNT_W(8)) u_a (
        .clk(clk), .reset(reset), .en(en_d & (sel == 0)), .clear(clr_d & (sel == 0)),
        .x_in(x_d), .y_out(y0), .match_count(cnt0), .state_out(st0));
    seq_detect_fsm #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .MOORE(1'b0), .CNT_W(8)) u_b (
        .clk(clk), .reset(reset), .en(en_d & (sel == 1)), .clear(clr_d & (sel == 1)),
        .x_in(x_d), .y_out(y1), .match_count(cnt1), .state_out(st1));
    seq_detect_fsm #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .MOORE(1'b1), .CNT_W(8)) u_c (
        .clk(clk), .reset(reset), .en(en_d & (sel == 2)), .clear(clr_d & (sel == 2)),
        .x_in(x_d), .y_out(y2), .match_count(cnt2), .state_out(st2));
    seq_detect_fsm #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .MOORE(1'b0), .CNT_W(2)) u_d (
        .clk(clk), .reset(reset), .en(en_d & (sel == 3)), .clear(clr_d & (sel == 3)),
        .x_in(x_d), .y_out(y3), .match_count(cnt3), .state_out(st3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        y_s   = 1'b0;
        cnt_s = '0;
        st_s  = '0;
        case (sel)
            0: begin y_s = y0; cnt_s = cnt0;          st_s = st0; end
            1: begin y_s = y1; cnt_s = cnt1;          st_s = st1; end
            2: begin y_s = y2; cnt_s = cnt2;          st_s = st2; end
            3: begin y_s = y3; cnt_s = {6'd0, cnt3};  st_s = st3; end
            default: ;
        endcase
    end

    function automatic vec_t v(input logic en, input logic clr, input logic x,
                               input logic cy, input logic y, input int cnt, input int st);
        vec_t r;
        r.en = en; r.clr = clr; r.x = x; r.chk_y = cy; r.y = y;
        r.cnt = 8'(cnt); r.st = 8'(st);
        return r;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s (dut %0d, t=%0t): got %0d expected %0d", name, sel, $time, act, exp);
        end
    endtask

    // Mealy y_out is checked combinationally before the edge; state, count
    // and Moore y_out are checked from the scoreboard after the edge.
    task automatic step(input int d, input vec_t vin);
        vec_t e;
        @(negedge clk);
        sel   = d;
        en_d  = vin.en;
        clr_d = vin.clr;
        x_d   = vin.x;
        sb_q.push_back(vin);
        #1;
        if (d != 2 && vin.chk_y) check("mealy_y", 8'(y_s), 8'(vin.y));
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        if (d == 2 && e.chk_y) check("moore_y", 8'(y_s), 8'(e.y));
        check("count", cnt_s, e.cnt);
        check("state", 8'(st_s), e.st);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int bits [4];
        int sts  [4];
        int c;

        tab_a = '{
            v(1,0,1, 1,0, 0,1), v(1,0,0, 1,0, 0,2), v(1,0,1, 1,0, 0,3), v(1,0,1, 1,1, 1,1),
            v(1,0,0, 1,0, 1,2), v(1,0,1, 1,0, 1,3), v(1,0,1, 1,1, 2,1), v(1,0,0, 1,0, 2,2),
            v(1,0,0, 1,0, 2,0), v(1,0,1, 1,0, 2,1), v(1,0,0, 1,0, 2,2), v(1,0,1, 1,0, 2,3),
            v(0,0,1, 1,0, 2,3), v(1,0,1, 1,1, 3,1), v(1,0,0, 1,0, 3,2), v(1,0,1, 1,0, 3,3),
            v(1,1,1, 0,0, 0,0), v(1,0,1, 1,0, 0,1), v(0,1,0, 1,0, 0,0)
        };
        tab_b = '{
            v(1,0,1, 1,0, 0,1), v(1,0,0, 1,0, 0,2), v(1,0,1, 1,0, 0,3), v(1,0,1, 1,1, 1,0),
            v(1,0,0, 1,0, 1,0), v(1,0,1, 1,0, 1,1), v(1,0,1, 1,0, 1,1)
        };
        tab_c = '{
            v(1,0,1, 1,0, 0,1), v(1,0,0, 1,0, 0,2), v(1,0,1, 1,0, 0,3), v(1,0,1, 1,1, 1,4),
            v(0,0,0, 1,1, 1,4), v(1,0,0, 1,0, 1,2), v(1,0,1, 1,0, 1,3), v(1,0,1, 1,1, 2,4),
            v(1,0,1, 1,0, 2,1), v(1,1,0, 1,0, 0,0)
        };
        bits = '{1, 0, 1, 1};
        sts  = '{1, 2, 3, 1};

        total = 0;
        bad   = 0;
        sel   = 0;
        en_d  = 1'b0;
        clr_d = 1'b0;
        x_d   = 1'b0;
        reset = 1'b0;

        #2;
        for (int i = 0; i < 4; i++) begin
            sel = i;
            #1;
            check("reset_state", 8'(st_s), 8'd0);
            check("reset_count", cnt_s, 8'd0);
            check("reset_y", 8'(y_s), 8'd0);
        end
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 19; i++) step(0, tab_a[i]);
        for (int i = 0; i < 7; i++)  step(1, tab_b[i]);
        for (int i = 0; i < 10; i++) step(2, tab_c[i]);

        // Qualified bits separated by idle cycles with random data.
        c = 0;
        for (int j = 0; j < 4; j++) begin
            if (j == 3) c = 1;
            step(0, v(1, 0, 1'(bits[j]), 1, (j == 3), c, sts[j]));
            for (int n = 0; n < 3; n++)
                step(0, v(0, 0, 1'($urandom_range(0, 1)), 1, 0, c, sts[j]));
        end

        // Asynchronous reset in the middle of a pattern.
        step(0, v(1,0,0, 1,0, 1,2));
        step(0, v(1,0,1, 1,0, 1,3));
        @(negedge clk);
        sel  = 0;
        en_d = 1'b1;
        x_d  = 1'b1;
        #1;
        check("pre_reset_mealy_y", 8'(y_s), 8'd1);
        #1;
        reset = 1'b0;
        #1;
        check("async_reset_state", 8'(st_s), 8'd0);
        check("async_reset_count", cnt_s, 8'd0);
        check("async_reset_y", 8'(y_s), 8'd0);
        @(posedge clk);
        #1;
        check("held_reset_state", 8'(st_s), 8'd0);
        @(negedge clk);
        reset = 1'b1;
        en_d  = 1'b0;
        step(0, v(1,0,1, 1,0, 0,1));
        step(0, v(1,0,1, 1,0, 0,1));

        // Counter saturation with a 2-bit counter.
        for (int r = 0; r < 5; r++) begin
            for (int j = 0; j < 4; j++) begin
                c = (j == 3) ? r + 1 : r;
                if (c > 3) c = 3;
                step(3, v(1, 0, 1'(bits[j]), 1, (j == 3), c, sts[j]));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
